// File: rtl/mem_ctrl_if.sv
// Bus bundle between the core load/store path, mem_ctrl and the block RAM.
// A request transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse with no back-pressure.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int XLEN       = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [XLEN-1:0]       req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [XLEN-1:0]       req_wdata;
  logic                  rsp_valid;
  logic [XLEN-1:0]       rsp_rdata;
  logic                  rsp_err;
  logic                  mem_rd_n;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [XLEN-1:0]       mem_wdata;
  logic [XLEN-1:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rd_n, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rd_n, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-outstanding load/store controller for a byte-enabled single-port RAM
// with a one-cycle registered read port; checks alignment/range and extends load data.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int XLEN       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_ctrl_if.slave  bus,
  output logic [1:0] dbg_state_o
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [3:0]            lanes_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [XLEN-1:0]       mem_wdata_q;
  logic [XLEN-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  accept;
  logic [1:0]            off_a;
  logic                  req_err;
  logic [3:0]            lanes_a;
  logic [XLEN-1:0]       wdata_a;
  logic [XLEN-1:0]       rdata_shift;
  logic [XLEN-1:0]       load_ext;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign off_a  = bus.req_addr[1:0];

  always_comb begin
    req_err = 1'b0;
    lanes_a = 4'b1111;
    wdata_a = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        lanes_a = 4'b0001 << off_a;
        wdata_a = {(XLEN/8){bus.req_wdata[7:0]}};
      end
      2'b01: begin
        req_err = off_a[0];
        lanes_a = 4'b0011 << off_a;
        wdata_a = {(XLEN/16){bus.req_wdata[15:0]}};
      end
      2'b10:   req_err = (off_a != 2'b00);
      default: req_err = 1'b1;
    endcase
    // Anything above the RAM's byte span is out of range.
    if ((bus.req_addr >> (ADDR_WIDTH + 2)) != '0) req_err = 1'b1;
  end

  assign rdata_shift = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = bus.mem_rdata;
    case (size_q)
      2'b00: load_ext = uns_q ? {{(XLEN-8){1'b0}}, rdata_shift[7:0]}
                              : {{(XLEN-8){rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01: load_ext = uns_q ? {{(XLEN-16){1'b0}}, rdata_shift[15:0]}
                              : {{(XLEN-16){rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d     = RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d     = RESP;
        rsp_rdata_d = load_ext;
        rsp_err_d   = 1'b0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lanes_q     <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        we_q        <= bus.req_we;
        off_q       <= off_a;
        size_q      <= bus.req_size;
        uns_q       <= bus.req_unsigned;
        lanes_q     <= lanes_a;
        mem_addr_q  <= bus.req_addr[ADDR_WIDTH+1:2];
        mem_wdata_q <= wdata_a;
      end
    end
  end

  // Strobes decode straight from state_q so an async reset drops them at once.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_rd_n  = !((state_q == ISSUE) && !we_q);
  assign bus.mem_we    = ((state_q == ISSUE) && we_q) ? lanes_q : 4'b0000;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-enabled RAM model, driver tasks, response
// scoreboard fed from an expected queue, final report.
module tb_mem_ctrl;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad   = 0;

  logic [32:0] exp_q[$];
  logic [31:0] ram [0:8191];

  mem_ctrl_if #(.ADDR_WIDTH(13), .XLEN(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(13), .XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  initial foreach (ram[i]) ram[i] = 32'h0;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    if (!bus.mem_rd_n) bus.mem_rdata <= ram[bus.mem_addr];
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'h0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    check({tag, "_rsp_err"},   {31'b0, bus.rsp_err}, 32'h0);
    check({tag, "_mem_rd_n"},  {31'b0, bus.mem_rd_n}, 32'h1);
    check({tag, "_mem_we"},    {28'b0, bus.mem_we}, 32'h0);
    check({tag, "_mem_addr"},  {19'b0, bus.mem_addr}, 32'h0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp act=%h exp=none", bus.rsp_rdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e[31:0]);
        check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e[32]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
  endtask

  // Single request with cycle-by-cycle checks of strobes, latency and req_ready.
  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [3:0] exp_lanes, input logic [31:0] exp_wdata);
    int lat;
    lat = exp_err ? 1 : (we ? 2 : 3);
    @(negedge clk);
    check({name, "_ready_idle"}, {31'b0, bus.req_ready}, 32'h1);
    set_req(we, addr, size, uns, wdata);
    bus.req_valid = 1'b1;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check({name, "_rsp_timing"}, {31'b0, bus.rsp_valid}, {31'b0, (k == lat)});
      check({name, "_ready_busy"}, {31'b0, bus.req_ready}, 32'h0);
      if (k == 1 && !exp_err) begin
        check({name, "_state_issue"}, {30'b0, dbg_state}, 32'h1);
        check({name, "_mem_addr"}, {19'b0, bus.mem_addr}, {19'b0, addr[14:2]});
        check({name, "_mem_we"}, {28'b0, bus.mem_we}, we ? {28'b0, exp_lanes} : 32'h0);
        check({name, "_mem_rd_n"}, {31'b0, bus.mem_rd_n}, we ? 32'h1 : 32'h0);
        if (we) check({name, "_mem_wdata"}, bus.mem_wdata, exp_wdata);
      end else begin
        check({name, "_mem_we_idle"}, {28'b0, bus.mem_we}, 32'h0);
        check({name, "_mem_rd_n_idle"}, {31'b0, bus.mem_rd_n}, 32'h1);
      end
    end
    @(negedge clk);
    check({name, "_ready_after"}, {31'b0, bus.req_ready}, 32'h1);
    check({name, "_no_extra_rsp"}, {31'b0, bus.rsp_valid}, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_busy;
  } b2b_t;

  b2b_t b2b[6];

  // req_valid stays high; each accept must be followed by the exact busy window.
  task automatic run_b2b();
    int busy;
    @(negedge clk);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("b2b_ready_idle", {31'b0, bus.req_ready}, 32'h1);
      set_req(b2b[i].we, b2b[i].addr, b2b[i].size, b2b[i].uns, b2b[i].wdata);
      exp_q.push_back({b2b[i].exp_err, b2b[i].exp_rdata});
      @(posedge clk);
      busy = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus.req_ready) break;
        busy++;
      end
      check($sformatf("b2b_busy_%0d", i), busy, b2b[i].exp_busy);
    end
    bus.req_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.req_valid = 1'b0;
    set_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    rst_n = 1'b0;
    #23;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    do_req("st_w",    1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF);
    do_req("ld_w",    1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0);
    do_req("st_b",    1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, 32'h0, 1'b0, 4'b1000, 32'h80808080);
    do_req("ld_bs",   1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 4'b0000, 32'h0);
    do_req("ld_bu",   1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0, 4'b0000, 32'h0);
    do_req("ld_bu1",  1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 32'h000000BE, 1'b0, 4'b0000, 32'h0);
    do_req("ld_hs0",  1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0, 4'b0000, 32'h0);
    do_req("st_h",    1'b1, 32'h22, 2'b01, 1'b0, 32'h00008001, 32'h0, 1'b0, 4'b1100, 32'h80018001);
    do_req("ld_hs",   1'b0, 32'h22, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 4'b0000, 32'h0);
    do_req("ld_hu",   1'b0, 32'h22, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, 4'b0000, 32'h0);
    do_req("ld_wu",   1'b0, 32'h20, 2'b10, 1'b1, 32'h0, 32'h80010000, 1'b0, 4'b0000, 32'h0);
    do_req("st_top",  1'b1, 32'h7FFC, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0, 4'b1111, 32'h12345678);
    do_req("ld_top",  1'b0, 32'h7FFC, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0, 4'b0000, 32'h0);

    do_req("err_h",   1'b0, 32'h21, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    do_req("err_w",   1'b0, 32'h02, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    do_req("err_sz",  1'b0, 32'h00, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    do_req("err_rng", 1'b0, 32'h8000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    do_req("err_st",  1'b1, 32'h8010, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, 4'b0000, 32'h0);
    do_req("ld_chk",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0, 4'b0000, 32'h0);

    b2b[0] = '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0, 3};
    b2b[1] = '{1'b1, 32'h30, 2'b10, 1'b0, 32'h000055AA, 32'h0,        1'b0, 2};
    b2b[2] = '{1'b0, 32'h30, 2'b01, 1'b1, 32'h0,        32'h000055AA, 1'b0, 3};
    b2b[3] = '{1'b1, 32'h31, 2'b00, 1'b0, 32'h0000007F, 32'h0,        1'b0, 2};
    b2b[4] = '{1'b0, 32'h30, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 1};
    b2b[5] = '{1'b0, 32'h30, 2'b10, 1'b0, 32'h0,        32'h00007FAA, 1'b0, 3};
    run_b2b();

    // Reset in CAPTURE: outputs drop at once and the load produces no response.
    @(negedge clk);
    set_req(1'b0, 32'h30, 2'b10, 1'b0, 32'h0);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_capture", {30'b0, dbg_state}, 32'h2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    check("mid_state", {30'b0, dbg_state}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req("ld_post", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0, 4'b0000, 32'h0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
